uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART_TX instance among N_REQ byte sources (loopback echo, status reporter, debug dump).
//  Picks a requester round-robin, latches its byte, pulses UART_TX i_tx_dr, then tracks o_tx_busy until the frame is sent.
//  An optional per-requester lock holds the grant across a multi-byte message so its bytes are never interleaved.
//  Sits between the byte sources and UART_TX; UART_TX o_serial drives o_uart_tx unchanged.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  DATA_W       8   byte width; equals the UART_TX i_data width
//  BUSY_TIMEOUT 15  cycles WAIT_BUSY waits for i_tx_busy to rise before abandoning the byte
// PORTS
//  i_clk       in   1             system clock, single clock domain
//  i_reset     in   1             reset, asynchronous assert, active-low (0 = reset)
//  i_req       in   N_REQ         per-requester byte valid, level; data must be stable while high
//  i_lock      in   N_REQ         per-requester hold-grant-after-this-byte, sampled with the byte
//  i_data      in   N_REQ*DATA_W  requester k byte on bits [k*DATA_W +: DATA_W]
//  o_ack       out  N_REQ         1-cycle pulse: requester's byte captured; requester may advance next cycle
//  o_tx_dr     out  1             to UART_TX i_tx_dr, 1-cycle start pulse
//  o_tx_data   out  DATA_W        to UART_TX i_data, held stable from ISSUE until back in IDLE
//  i_tx_busy   in   1             from UART_TX o_tx_busy
//  o_owner     out  $clog2(N_REQ) index of the current or last granted requester
//  o_active    out  1             high in every state except IDLE
//  o_timeout   out  1             1-cycle pulse when the BUSY_TIMEOUT abort fires
// BEHAVIOUR
//  Reset (i_reset=0, async): state=IDLE; o_ack, o_tx_dr, o_tx_data, o_owner, o_active, o_timeout = 0;
//   rr pointer=0; lock flag cleared. Aborts any transfer immediately; the byte in flight is lost.
//  FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: if the lock flag is set, only o_owner is eligible (its i_req is awaited; other requests are ignored).
//   Otherwise the winner is the first requester with i_req=1 scanning from (ptr+1) mod N_REQ upward.
//   Leave IDLE only if i_tx_busy=0 and a winner exists.
//  ISSUE (1 cycle): register o_tx_data=winner byte, o_owner=winner, lock flag=i_lock[winner];
//   o_ack[winner]=1 and o_tx_dr=1 in this same cycle; ptr=winner.
//  WAIT_BUSY: exit to WAIT_DONE when i_tx_busy=1. After BUSY_TIMEOUT cycles with busy low:
//   pulse o_timeout, clear the lock flag, return to IDLE.
//  WAIT_DONE: exit to IDLE on i_tx_busy=0. Minimum gap from one o_tx_dr to the next is 3 cycles + busy time.
//  Lock: while the flag is set, the owner keeps the grant on each next byte (ptr is not advanced past it).
//   The flag clears when a byte is issued with i_lock=0. A dropped i_req never revokes a lock.
//  Simultaneous: a request in the same cycle as an ack to another requester is served next in RR order.
//   Requests that drop before the grant are simply not served (no memory).
//  Width: ptr/owner width is $clog2(N_REQ); wrap is mod N_REQ (N_REQ not a power of 2 -> explicit wrap compare).
//  Timeout counter is $clog2(BUSY_TIMEOUT+1) bits, saturating, cleared on entry to WAIT_BUSY.
//  Invariants: o_ack is one-hot or 0; o_tx_dr == |o_ack; no o_tx_dr while i_tx_busy=1.
// STRUCTURE
//  Shared package uart_pkg: state encoding (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE), DATA_W default,
//   clog2 helper.
//  Sub-module rr_pick (combinational): inputs req vector and ptr; outputs winner index and valid.
//   The FSM, lock flag, timeout counter and data register stay in uart_tx_arbiter.
// TESTING (bench uses a real UART_TX; CLKS_PER_BIT small)
//  1 Reset idle: i_reset=0 then 1, no req -> all outputs 0, o_tx_dr never pulses.
//  2 Single byte: i_req[2]=1, byte 8'h41 -> o_ack[2] and o_tx_dr in the same cycle; serial frame 0x41;
//     o_active low after busy falls.
//  3 Round robin: i_req=4'b1111, bytes 8'h10,8'h11,8'h12,8'h13 held -> grant order 1,2,3,0,1 from reset ptr=0.
//  4 Lock: req0 sends 8'hA0,8'hA1,8'hA2 with i_lock=1,1,0 while req1 is high -> wire order A0,A1,A2 then req1's byte.
//  5 Timeout: i_tx_busy forced 0 after o_tx_dr -> o_timeout pulse 15 cycles later, FSM back to IDLE.
//     Also check: lock cleared.
//  6 Reset mid-frame: pull i_reset low during WAIT_DONE -> outputs 0 immediately.
//     After release, ptr=0 and the next grant follows the RR rule from 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
package uart_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  // Ceiling log2 for sizing index and counter fields.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request scanning upward from ptr+1, wrapping mod N_REQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [clog2(N_REQ)-1:0] ptr,
  output logic [clog2(N_REQ)-1:0] winner,
  output logic                    valid
);

  localparam int unsigned PW = clog2(N_REQ);

  int unsigned     idx;
  logic [PW-1:0]   idx_t;

  // Scan N_REQ positions starting after ptr; explicit wrap handles non-power-of-2 N_REQ.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    idx_t  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_t = PW'(idx);
      if (!valid && req[idx_t]) begin
        valid  = 1'b1;
        winner = idx_t;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources, with per-source grant lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_lock,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  output logic [N_REQ-1:0]          o_ack,
  output logic                      o_tx_dr,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_busy,
  output logic [clog2(N_REQ)-1:0]   o_owner,
  output logic                      o_active,
  output logic                      o_timeout
);

  localparam int unsigned PW = clog2(N_REQ);
  localparam int unsigned CW = clog2(BUSY_TIMEOUT + 1);

  arb_state_t      state, state_n;
  logic [PW-1:0]   pick_idx, win;
  logic            pick_vld, win_vld;
  logic            lock_flag;
  logic [CW-1:0]   cnt;
  logic            go;

  // o_owner doubles as the round-robin pointer: both always hold the last granted index.
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (i_req),
    .ptr    (o_owner),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  // Eligibility: a held lock restricts the grant to the current owner.
  always_comb begin
    win     = pick_idx;
    win_vld = pick_vld;
    if (lock_flag) begin
      win     = o_owner;
      win_vld = i_req[o_owner];
    end
  end

  // Next-state logic and single-cycle pulse outputs.
  always_comb begin
    state_n   = state;
    go        = 1'b0;
    o_tx_dr   = 1'b0;
    o_ack     = '0;
    o_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (!i_tx_busy && win_vld) begin
          go      = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        o_tx_dr        = 1'b1;
        o_ack[o_owner] = 1'b1;
        state_n        = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_n = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          o_timeout = 1'b1;
          state_n   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_active = (state != IDLE);

  // State, captured byte/owner/lock, and busy-wait counter.
  // Capture happens on the IDLE->ISSUE edge so the registered values are
  // already valid while o_tx_dr and o_ack pulse during ISSUE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      o_owner   <= '0;
      o_tx_data <= '0;
      lock_flag <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        o_owner   <= win;
        o_tx_data <= i_data[win*DATA_W +: DATA_W];
        lock_flag <= i_lock[win];
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT_BUSY && !i_tx_busy && cnt != CW'(BUSY_TIMEOUT)) begin
        cnt <= cnt + CW'(1);
      end
      if (o_timeout) lock_flag <= 1'b0;
    end
  end

endmodule
